// File: rtl/i2c_arb_pkg.sv
// Shared definitions for the i2c_bus_arbiter slice: FSM states, rw encodings
// and the EEPROM device-address base.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    COMPLETE
  } arb_state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Upper nibble of the 7-bit address used by the on-board EEPROMs.
  localparam logic [3:0] EEPROM_ADDR_BASE = 4'b1010;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping modulo NUM_REQ. Returns the one-hot grant and its index.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  // Scan the requesters starting from rr_ptr; the first hit wins.
  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = IW'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one i2c_controller among NUM_REQ clients.
// Each client posts a one-byte transaction; the arbiter drives the controller,
// follows its ready handshake and returns read data with a done pulse.
// Optional watchdog: define I2C_ARB_TIMEOUT_EN to abort stuck transactions
// after TIMEOUT_CYCLES (pulses err with done and resets the controller).
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_600_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_rw,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           rd_data,
  output logic [NUM_REQ-1:0]   err,
  output logic [6:0]           i2c_addr,
  output logic [7:0]           i2c_data_in,
  output logic                 i2c_rw,
  output logic                 i2c_enable,
  output logic                 i2c_rst,
  input  logic                 i2c_ready,
  input  logic [7:0]           i2c_data_out
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_t         state, state_n;
  logic [NUM_REQ-1:0] gnt_q, pick_gnt;
  logic [IW-1:0]      sel_q, pick_idx, rr_ptr;
  logic [6:0]         sel_addr;
  logic [7:0]         sel_data;
  logic               sel_rw;
  logic               tmo;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic; the watchdog (when built) overrides both wait states.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (|req && i2c_ready) state_n = GRANT;
      GRANT:     state_n = START;
      START:     state_n = WAIT_BUSY;
      WAIT_BUSY: if (tmo) state_n = COMPLETE;
                 else if (!i2c_ready) state_n = WAIT_DONE;
      WAIT_DONE: if (tmo || i2c_ready) state_n = COMPLETE;
      COMPLETE:  state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Bus-facing strobes decoded from the registered state.
  assign gnt        = (state != IDLE) ? gnt_q : '0;
  assign done       = (state == COMPLETE) ? gnt_q : '0;
  assign i2c_enable = (state == START);

  // Owner captured when arbitration resolves; pointer moves past it on retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q  <= '0;
      sel_q  <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && state_n == GRANT) begin
        gnt_q <= pick_gnt;
        sel_q <= pick_idx;
      end
      if (state == COMPLETE)
        rr_ptr <= (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + IW'(1);
    end
  end

  // Mux the owning client's transaction fields.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_rw   = RW_WRITE;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        sel_addr = req_addr[i*7 +: 7];
        sel_data = req_data[i*8 +: 8];
        sel_rw   = req_rw[i];
      end
    end
  end

  // Controller operands latched once per transaction, stable until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i2c_addr    <= '0;
      i2c_data_in <= '0;
      i2c_rw      <= RW_WRITE;
    end else if (state == GRANT) begin
      i2c_addr    <= sel_addr;
      i2c_data_in <= sel_data;
      i2c_rw      <= sel_rw;
    end
  end

  // Read data captured only on a normally completing read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_data <= '0;
    else if (state == WAIT_DONE && i2c_ready && !tmo && i2c_rw == RW_READ)
      rd_data <= i2c_data_out;
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          timed_out;
  logic          rst_hold;

  // cnt holds cycles elapsed since START, so expiry lands TIMEOUT_CYCLES after it.
  assign tmo = (state == WAIT_BUSY || state == WAIT_DONE) &&
               (cnt >= CW'(TIMEOUT_CYCLES - 1));

  // Watchdog counter, restarted each START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                              cnt <= '0;
    else if (state == START)                               cnt <= CW'(1);
    else if ((state == WAIT_BUSY || state == WAIT_DONE) && !tmo) cnt <= cnt + CW'(1);
  end

  // Remember that the retiring transaction was aborted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   timed_out <= 1'b0;
    else if (tmo)               timed_out <= 1'b1;
    else if (state == COMPLETE) timed_out <= 1'b0;
  end

  // Controller reset: follows system reset, plus a two-cycle pulse on expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i2c_rst  <= 1'b1;
      rst_hold <= 1'b0;
    end else if (tmo) begin
      i2c_rst  <= 1'b1;
      rst_hold <= 1'b1;
    end else begin
      i2c_rst  <= rst_hold;
      rst_hold <= 1'b0;
    end
  end

  assign err = (state == COMPLETE && timed_out) ? gnt_q : '0;
`else
  assign tmo = 1'b0;
  assign err = '0;

  // Controller reset follows system reset, released on the first clock after it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) i2c_rst <= 1'b1;
    else      i2c_rst <= 1'b0;
  end

  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed steps plus randomized
// request batches, checked against a transaction-level round-robin model.
// The watchdog step is built only when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_bus_arbiter;
  import i2c_arb_pkg::*;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*7-1:0] req_addr;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_rw;
  logic [N-1:0]   gnt, done, err;
  logic [7:0]     rd_data;
  logic [6:0]     i2c_addr;
  logic [7:0]     i2c_data_in;
  logic           i2c_rw, i2c_enable, i2c_rst, i2c_ready;
  logic [7:0]     i2c_data_out;

  // Controller stand-in state and knobs.
  logic       ctl_busy, force_low, ctl_hang;
  logic [7:0] ctl_next;
  int unsigned m_acc, m_bsy;

  // Reference model state.
  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_ptr;
  logic [7:0] exp_rd;
  logic [6:0] c_addr [N];
  logic [7:0] c_data [N];
  logic       c_rw   [N];
  bit         kept   [N];

  assign i2c_ready = !ctl_busy && !force_low;

  always #5 clk = ~clk;

  i2c_bus_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_rw       (req_rw),
    .gnt          (gnt),
    .done         (done),
    .rd_data      (rd_data),
    .err          (err),
    .i2c_addr     (i2c_addr),
    .i2c_data_in  (i2c_data_in),
    .i2c_rw       (i2c_rw),
    .i2c_enable   (i2c_enable),
    .i2c_rst      (i2c_rst),
    .i2c_ready    (i2c_ready),
    .i2c_data_out (i2c_data_out)
  );

  // Controller stand-in: on enable, goes busy after 1..3 cycles, stays busy
  // 1..6 cycles, then returns ctl_next with ready high.
  initial begin
    ctl_busy     = 1'b0;
    i2c_data_out = 8'h00;
  end
  always begin
    @(negedge clk);
    if (i2c_enable === 1'b1 && !ctl_hang) begin
      m_acc = $urandom_range(3, 1);
      m_bsy = $urandom_range(6, 1);
      repeat (m_acc) @(posedge clk);
      #1;
      ctl_busy     = 1'b1;
      i2c_data_out = 8'($urandom);
      repeat (m_bsy) @(posedge clk);
      #1;
      i2c_data_out = ctl_next;
      ctl_busy     = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang, required completion");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int c);
    logic [N-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: the first pending client at or after the pointer.
  function automatic int next_client(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++)
      if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic post(input int i, input logic [6:0] a, input logic [7:0] d, input logic rw);
    c_addr[i] = a;
    c_data[i] = d;
    c_rw[i]   = rw;
    req_addr[i*7 +: 7] = a;
    req_data[i*8 +: 8] = d;
    req_rw[i]          = rw;
    req[i]             = 1'b1;
  endtask

  // One complete transaction for client c; byte_v < 0 picks a random read byte.
  task automatic serve(input int c, input bit drop_early, input bit keep, input int byte_v);
    int t;
    ctl_next = (byte_v < 0) ? 8'($urandom) : 8'(byte_v);
    t = 0;
    while (gnt === '0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("gnt_wait", 32'(t < 50), 1);
    check("gnt_owner", gnt, onehot(c));
    @(negedge clk);
    check("enable_pulse", i2c_enable, 1);
    check("i2c_addr", i2c_addr, c_addr[c]);
    check("i2c_data_in", i2c_data_in, c_data[c]);
    check("i2c_rw", i2c_rw, c_rw[c]);
    if (drop_early) req[c] = 1'b0;
    @(negedge clk);
    check("enable_single", i2c_enable, 0);
    t = 0;
    while (done === '0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_wait", 32'(t < 50), 1);
    check("done_owner", done, onehot(c));
    check("err_quiet", err, 0);
    if (c_rw[c] == RW_READ) exp_rd = ctl_next;
    if (!keep) req[c] = 1'b0;
    exp_ptr = (c + 1) % N;
    @(negedge clk);
    check("rd_data", rd_data, exp_rd);
    check("done_single", done, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst     = 1'b1;
    exp_ptr = 0;
    exp_rd  = 8'h00;
  endtask

  initial begin
    int c, t;
    bit keep, early;
    logic [N-1:0] mask;

    rst = 1'b0; req = '0; req_addr = '0; req_data = '0; req_rw = '0;
    force_low = 1'b0; ctl_hang = 1'b0; ctl_next = 8'h00;
    exp_ptr = 0; exp_rd = 8'h00;
    for (int i = 0; i < N; i++) begin
      c_addr[i] = '0; c_data[i] = '0; c_rw[i] = RW_WRITE; kept[i] = 1'b0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_enable", i2c_enable, 0);
    check("rst_i2c_rst", i2c_rst, 1);
    check("rst_i2c_addr", i2c_addr, 0);
    check("rst_i2c_data_in", i2c_data_in, 0);
    check("rst_i2c_rw", i2c_rw, 0);
    rst = 1'b1;
    @(negedge clk);
    check("i2c_rst_release", i2c_rst, 0);

    // Single read from client 1 at the EEPROM address; client drops req mid-flight.
    post(1, {EEPROM_ADDR_BASE, 3'b000}, 8'h10, RW_READ);
    @(negedge clk);
    check("grant_latency", gnt, onehot(1));
    serve(1, 1'b1, 1'b0, 8'hA5);
    check("read_a5", rd_data, 8'hA5);

    // Fairness from reset: all four held, expect 0,1,2,3 then again.
    pulse_reset();
    for (int i = 0; i < N; i++) post(i, 7'($urandom), 8'($urandom), 1'($urandom));
    for (int k = 0; k < 2 * N; k++) begin
      c = next_client(req, exp_ptr);
      serve(c, 1'b0, k < N, -1);
    end
    check("fair_all_dropped", req, 0);

    // A write leaves rd_data untouched.
    post(0, 7'h21, 8'h00, RW_READ);
    serve(0, 1'b0, 1'b0, 8'h3C);
    post(2, 7'h48, 8'h77, RW_WRITE);
    serve(2, 1'b0, 1'b0, -1);
    check("write_keeps_rd", rd_data, 8'h3C);

    // Ready low at idle blocks arbitration.
    force_low = 1'b1;
    post(0, 7'h33, 8'h5A, RW_WRITE);
    repeat (4) begin
      @(negedge clk);
      check("no_gnt_ready_low", gnt, 0);
    end
    force_low = 1'b0;
    @(negedge clk);
    check("gnt_after_ready", gnt, onehot(0));
    serve(0, 1'b0, 1'b0, -1);

    // Reset during WAIT_DONE.
    post(3, 7'h52, 8'h01, RW_READ);
    t = 0;
    while (!ctl_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("busy_wait", 32'(t < 50), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_gnt", gnt, 0);
    check("midrst_done", done, 0);
    check("midrst_i2c_rst", i2c_rst, 1);
    check("midrst_enable", i2c_enable, 0);
    req[3] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_done", done, 0);
    end
    rst = 1'b1; exp_ptr = 0; exp_rd = 8'h00;
    t = 0;
    while (ctl_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    post(2, 7'h50, 8'h02, RW_READ);
    serve(2, 1'b0, 1'b0, -1);

    // Randomized batches; some clients hold req once and must yield to others.
    for (int b = 0; b < 25; b++) begin
      mask = N'($urandom_range(2 ** N - 1, 1));
      for (int i = 0; i < N; i++) begin
        kept[i] = 1'b0;
        if (mask[i]) post(i, 7'($urandom), 8'($urandom), 1'($urandom));
      end
      t = 0;
      while (req != '0 && t < 4 * N) begin
        c     = next_client(req, exp_ptr);
        keep  = ($urandom_range(3, 0) == 0) && !kept[c];
        early = !keep && ($urandom_range(1, 0) == 1);
        if (keep) kept[c] = 1'b1;
        serve(c, early, keep, -1);
        t++;
      end
      check("batch_drained", req, 0);
    end

`ifdef I2C_ARB_TIMEOUT_EN
    // Watchdog: controller never goes busy.
    ctl_hang = 1'b1;
    post(0, 7'h50, 8'h44, RW_READ);
    post(1, 7'h51, 8'h55, RW_WRITE);
    c = next_client(req, exp_ptr);
    t = 0;
    while (gnt === '0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("tmo_gnt", gnt, onehot(c));
    @(negedge clk);
    check("tmo_enable", i2c_enable, 1);
    t = 0;
    while (done === '0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("tmo_latency", t, 100);
    check("tmo_done", done, onehot(c));
    check("tmo_err", err, onehot(c));
    check("tmo_i2c_rst_1", i2c_rst, 1);
    ctl_hang = 1'b0;
    req[c]   = 1'b0;
    exp_ptr  = (c + 1) % N;
    @(negedge clk);
    check("tmo_i2c_rst_2", i2c_rst, 1);
    check("tmo_err_single", err, 0);
    check("tmo_rd_kept", rd_data, exp_rd);
    @(negedge clk);
    check("tmo_i2c_rst_off", i2c_rst, 0);
    serve(next_client(req, exp_ptr), 1'b0, 1'b0, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
Shares the single i2c_controller among NUM_REQ client blocks, e.g. the EEPROM reader, sensor pollers and the config loader. Clients post one-byte transactions. The arbiter picks a client by round-robin, drives the controller's addr/data_in/rw/enable, tracks its ready handshake, and returns read data with a per-client done pulse. It sits between the client wrappers and the i2c_controller instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 1_600_000, watchdog limit in clk cycles (100 ms at 16 MHz); used only with I2C_ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (0 = reset)
req  in  NUM_REQ  per-client request level, held until that client's done
req_addr  in  NUM_REQ*7  per-client 7-bit device address; client i occupies bits [7i+6:7i]
req_data  in  NUM_REQ*8  per-client write byte / register pointer
req_rw  in  NUM_REQ  per-client direction; 0 = write, 1 = read
gnt  out  NUM_REQ  one-hot; marks the client that owns the bus
done  out  NUM_REQ  one-cycle completion pulse to the owning client
rd_data  out  8  byte returned by the last completed read; held until the next read completes
err  out  NUM_REQ  one-cycle timeout flag, pulsed together with done
i2c_addr  out  7  to controller addr
i2c_data_in  out  8  to controller data_in
i2c_rw  out  1  to controller rw
i2c_enable  out  1  to controller enable; single-cycle pulse
i2c_rst  out  1  to controller rst; active-high
i2c_ready  in  1  from controller; 1 = idle
i2c_data_out  in  8  from controller data_out

Behaviour:
- Reset values (rst=0): gnt=0, done=0, err=0, rd_data=0, i2c_enable=0, i2c_rst=1, i2c_addr=0, i2c_data_in=0, i2c_rw=0, rr_ptr=0, state=IDLE.
- i2c_rst releases to 0 on the first clk edge after rst deasserts.
- The FSM runs IDLE -> GRANT -> START -> WAIT_BUSY -> WAIT_DONE -> COMPLETE -> IDLE.
- IDLE: if any req bit is set and i2c_ready=1, select the first set bit at or after rr_ptr, with modular wrap. Go to GRANT.
- GRANT: assert gnt[sel]. Latch req_addr, req_data and req_rw of client sel into i2c_addr, i2c_data_in and i2c_rw. The latched values are stable for the whole transaction.
- START: pulse i2c_enable for exactly one cycle. Go to WAIT_BUSY.
- WAIT_BUSY: wait for i2c_ready=0, meaning the controller accepted the transaction, then go to WAIT_DONE.
- WAIT_DONE: wait for i2c_ready=1.
  - On that edge, if rw=1, capture i2c_data_out into rd_data.
  - Go to COMPLETE.
- COMPLETE: pulse done[sel] for one cycle, set rr_ptr=(sel+1) mod NUM_REQ, deassert gnt. Go to IDLE.
- Latency: from a req seen in IDLE to i2c_enable is 2 cycles. The minimum IDLE-to-IDLE turnaround is 5 cycles plus the controller busy time.
- Boundary cases:
  - Requests that rise in the same cycle: the round-robin pointer decides; there is no fixed priority.
  - A client drops req mid-transaction: the transaction still completes and done still pulses.
  - A client keeps req high after its done: it is re-arbitrated only after the other pending clients.
  - Only one client requesting: it is served back-to-back.
  - i2c_ready=0 while in IDLE: no grant is issued.
  - A write never changes rd_data.
  - rst asserted mid-transaction: everything returns to reset values immediately, no done is issued, and i2c_rst resets the controller.
- Without the watchdog (I2C_ARB_TIMEOUT_EN undefined), the arbiter waits indefinitely in WAIT_BUSY and WAIT_DONE.

Optional Feature:
Macro I2C_ARB_TIMEOUT_EN.
- Defined: a cycle counter starts at START. If it reaches TIMEOUT_CYCLES while in WAIT_BUSY or WAIT_DONE:
  - assert i2c_rst for 2 cycles;
  - pulse err[sel] and done[sel] together;
  - leave rd_data unchanged;
  - advance rr_ptr as normal.
- Undefined: no counter is built, err is tied to 0, and i2c_rst only follows system reset.

Decomposition:
- Shared package i2c_arb_pkg holds:
  - the FSM state encoding (IDLE, GRANT, START, WAIT_BUSY, WAIT_DONE, COMPLETE);
  - the constants RW_WRITE=0 and RW_READ=1;
  - the EEPROM device-address base 4'b1010.
- One sub-module, rr_pick: combinational round-robin picker. Inputs are req and rr_ptr; outputs are a one-hot grant and its encoded index.

Test Plan:
- Single read: client 1 posts addr=0x50, data=0x10, rw=1; the controller model returns 0xA5. Expect i2c_enable as a single pulse 2 cycles after req, i2c_addr=0x50, then done[1]=1 for one cycle and rd_data=0xA5.
- Fairness: all 4 req high from reset. Expect grants in order 0,1,2,3,0. No client is served twice while another is pending.
- Write does not touch rd_data: rd_data=0x3C, then client 2 writes 0x77. Expect i2c_rw=0, i2c_data_in=0x77, done[2] pulses, rd_data stays 0x3C.
- Reset mid-op: rst=0 during WAIT_DONE. Expect gnt=0, no done, i2c_rst=1; after rst releases, a fresh request completes normally.
- Ready low at idle: hold i2c_ready=0 with req[0]=1. Expect no gnt. Raise ready: expect gnt[0] on the following cycle.
- Timeout (macro on, TIMEOUT_CYCLES=100): the controller model never drops ready. Expect i2c_rst high for 2 cycles and err[0]/done[0] pulsing together 100 cycles after START; the next client is served afterwards.
